// File: rtl/fp_check_sequencer.sv
// Self-check sequencer: walks (A, B, expected C) triples from the register file, feeds A/B to
// the FP adder and scores the sum against C, driving pass/fail counters and the board LED.
module fp_check_sequencer #(
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned NUM_TESTS = 3,
  parameter bit          ZERO_EQ   = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] rf_addr,
  output logic              rf_rd_en,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic [DATA_W-1:0] add_a,
  output logic [DATA_W-1:0] add_b,
  input  logic [DATA_W-1:0] add_sum,
  output logic              busy,
  output logic              done,
  output logic [3:0]        pass_cnt,
  output logic [3:0]        fail_cnt,
  output logic [3:0]        first_fail,
  output logic              led
);

  localparam logic [3:0] LastK  = 4'(NUM_TESTS - 1);
  localparam logic [3:0] NoFail = 4'hF;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StRdA  = 3'd1,
    StRdB  = 3'd2,
    StRdC  = 3'd3,
    StCapC = 3'd4,
    StCmp  = 3'd5,
    StDone = 3'd6
  } state_e;

  state_e state_q, state_d;

  logic [3:0]        k_q;
  logic [3:0]        pass_q, fail_q, first_fail_q;
  logic              led_q;
  logic [DATA_W-1:0] add_a_q, add_b_q, c_q;
  logic [ADDR_W-1:0] base;
  logic              zero_both, eq;

  // Signed zeros differ only in bit DATA_W-1.
  assign zero_both = (add_sum[DATA_W-2:0] == '0) && (c_q[DATA_W-2:0] == '0);
  assign eq        = (add_sum == c_q) || (ZERO_EQ && zero_both);
  assign base      = ADDR_W'(3 * 32'(k_q));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StRdA;
      StRdA:   state_d = StRdB;
      StRdB:   state_d = StRdC;
      StRdC:   state_d = StCapC;
      StCapC:  state_d = StCmp;
      StCmp:   state_d = (k_q == LastK) ? StDone : StRdA;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rf_addr  = '0;
    rf_rd_en = 1'b0;
    case (state_q)
      StRdA: begin
        rf_addr  = base;
        rf_rd_en = 1'b1;
      end
      StRdB: begin
        rf_addr  = base + ADDR_W'(1);
        rf_rd_en = 1'b1;
      end
      StRdC: begin
        rf_addr  = base + ADDR_W'(2);
        rf_rd_en = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);

  // Read data lags the address by one cycle, so each capture is one state after its read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k_q          <= '0;
      pass_q       <= '0;
      fail_q       <= '0;
      first_fail_q <= NoFail;
      led_q        <= 1'b0;
      add_a_q      <= '0;
      add_b_q      <= '0;
      c_q          <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            k_q          <= '0;
            pass_q       <= '0;
            fail_q       <= '0;
            first_fail_q <= NoFail;
            led_q        <= 1'b0;
          end
        end
        StRdB:  add_a_q <= rf_rdata;
        StRdC:  add_b_q <= rf_rdata;
        StCapC: c_q     <= rf_rdata;
        StCmp: begin
          if (eq) begin
            pass_q <= pass_q + 4'd1;
          end else begin
            fail_q <= fail_q + 4'd1;
            if (first_fail_q == NoFail) first_fail_q <= k_q;
          end
          if (k_q != LastK) k_q <= k_q + 4'd1;
        end
        StDone: led_q <= (fail_q == 4'd0);
        default: ;
      endcase
    end
  end

  assign add_a      = add_a_q;
  assign add_b      = add_b_q;
  assign pass_cnt   = pass_q;
  assign fail_cnt   = fail_q;
  assign first_fail = first_fail_q;
  assign led        = led_q;

endmodule

// File: tb/tb_fp_check_sequencer.sv
// Directed bench for fp_check_sequencer: registered RF model, table-driven FP adder model,
// one instance with signed-zero equality and one with bit-exact compare.
module tb_fp_check_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;

  always #5 clk = ~clk;

  logic [31:0] mem [32];

  logic [4:0]  addr1, addr0;
  logic        rd_en1, rd_en0;
  logic [31:0] rdata1, rdata0;
  logic [31:0] a1, b1, a0, b0, sum1, sum0;
  logic        busy1, busy0, done1, done0, led1, led0;
  logic [3:0]  pass1, fail1, ff1, pass0, fail0, ff0;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  logic rec_en = 1'b0;
  logic [4:0] addr_log[$];

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h40400000 && b == 32'h3FC00000) return 32'h40900000;
    if (a == 32'h3F800000 && b == 32'hBF800000) return 32'h00000000;
    return 32'h7FC00000;
  endfunction

  assign sum1 = fadd(a1, b1);
  assign sum0 = fadd(a0, b0);

  always @(posedge clk) begin
    rdata1 <= mem[addr1];
    rdata0 <= mem[addr0];
  end

  always @(negedge clk) begin
    if (done1) done_cnt++;
    if (rec_en && rd_en1) addr_log.push_back(addr1);
  end

  fp_check_sequencer #(.ADDR_W(5), .DATA_W(32), .NUM_TESTS(3), .ZERO_EQ(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start),
    .rf_addr(addr1), .rf_rd_en(rd_en1), .rf_rdata(rdata1),
    .add_a(a1), .add_b(b1), .add_sum(sum1),
    .busy(busy1), .done(done1), .pass_cnt(pass1), .fail_cnt(fail1),
    .first_fail(ff1), .led(led1)
  );

  fp_check_sequencer #(.ADDR_W(5), .DATA_W(32), .NUM_TESTS(3), .ZERO_EQ(1'b0)) dut_exact (
    .clk(clk), .reset(reset), .start(start),
    .rf_addr(addr0), .rf_rd_en(rd_en0), .rf_rdata(rdata0),
    .add_a(a0), .add_b(b0), .add_sum(sum0),
    .busy(busy0), .done(done0), .pass_cnt(pass0), .fail_cnt(fail0),
    .first_fail(ff0), .led(led0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load_base();
    for (int t = 0; t < 3; t++) begin
      mem[3*t]   = 32'h40400000;
      mem[3*t+1] = 32'h3FC00000;
      mem[3*t+2] = 32'h40900000;
    end
  endtask

  // Returns the cycle (counting the cycle after the accept edge as 1) in which done is seen.
  task automatic launch(input string tag, output int cyc);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 2) chk({tag, "_busy_mid"}, 32'(busy1), 32'd1);
      if (done1) begin
        cyc = n;
        break;
      end
    end
    chk({tag, "_done_cycle"}, cyc, 16);
  endtask

  task automatic after_run(input string tag, input logic [3:0] p, input logic [3:0] f,
                           input logic [3:0] ff, input logic l);
    @(negedge clk);
    chk({tag, "_pass"}, 32'(pass1), 32'(p));
    chk({tag, "_fail"}, 32'(fail1), 32'(f));
    chk({tag, "_first_fail"}, 32'(ff1), 32'(ff));
    chk({tag, "_led"}, 32'(led1), 32'(l));
    chk({tag, "_busy_idle"}, 32'(busy1), 32'd0);
  endtask

  initial begin
    int cyc;
    int base_cnt;
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    load_base();

    // Power-on reset.
    #3 reset = 1'b0;
    #1;
    chk("por_busy", 32'(busy1), 32'd0);
    chk("por_first_fail", 32'(ff1), 32'hF);
    chk("por_led", 32'(led1), 32'd0);
    @(negedge clk) reset = 1'b1;

    // All-pass run.
    launch("t2", cyc);
    after_run("t2", 4'd3, 4'd0, 4'hF, 1'b1);
    chk("t2_add_a_hold", a1, 32'h40400000);
    chk("t2_add_b_hold", b1, 32'h3FC00000);
    chk("t2_exact_pass", 32'(pass0), 32'd3);

    // Asynchronous reset mid-cycle takes effect without a clock edge.
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("t1_rf_addr", 32'(addr1), 32'd0);
    chk("t1_rd_en", 32'(rd_en1), 32'd0);
    chk("t1_add_a", a1, 32'd0);
    chk("t1_add_b", b1, 32'd0);
    chk("t1_busy", 32'(busy1), 32'd0);
    chk("t1_done", 32'(done1), 32'd0);
    chk("t1_pass", 32'(pass1), 32'd0);
    chk("t1_fail", 32'(fail1), 32'd0);
    chk("t1_first_fail", 32'(ff1), 32'hF);
    chk("t1_led", 32'(led1), 32'd0);
    @(negedge clk) reset = 1'b1;

    // Wrong expected value in triple 1.
    mem[5] = 32'h40A00000;
    launch("t3", cyc);
    after_run("t3", 4'd2, 4'd1, 4'd1, 1'b0);

    // 1 + (-1) = +0 against expected -0.
    mem[3] = 32'h3F800000;
    mem[4] = 32'hBF800000;
    mem[5] = 32'h80000000;
    launch("t4", cyc);
    after_run("t4z", 4'd3, 4'd0, 4'hF, 1'b1);
    chk("t4x_pass", 32'(pass0), 32'd2);
    chk("t4x_fail", 32'(fail0), 32'd1);
    chk("t4x_first_fail", 32'(ff0), 32'd1);
    chk("t4x_led", 32'(led0), 32'd0);

    // start pulses while busy are ignored.
    base_cnt = done_cnt;
    rec_en = 1'b1;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 1; n <= 24; n++) begin
      @(negedge clk);
      start = (n == 3 || n == 9);
    end
    start = 1'b0;
    rec_en = 1'b0;
    chk("t5_done_count", done_cnt - base_cnt, 1);
    chk("t5_addr_count", addr_log.size(), 9);
    for (int i = 0; i < 9 && i < addr_log.size(); i++)
      chk($sformatf("t5_addr%0d", i), 32'(addr_log[i]), i);
    chk("t5_busy_end", 32'(busy1), 32'd0);

    // Reset aborts a run in its 7th cycle; the next run is unaffected.
    load_base();
    base_cnt = done_cnt;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("t6_abort_busy", 32'(busy1), 32'd0);
    chk("t6_abort_pass", 32'(pass1), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    chk("t6_no_done", done_cnt - base_cnt, 0);
    launch("t6", cyc);
    after_run("t6", 4'd3, 4'd0, 4'hF, 1'b1);
    chk("t6_one_done", done_cnt - base_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
